// File: rtl/pipe_stage_skid.sv
// Registered pipeline stage with a 2-entry skid buffer, valid/ready handshake and flush-to-bubble.
// Define PIPE_STAGE_STATS_EN to add saturating stall/transfer counters.
module pipe_stage_skid #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   NOP_VALUE = {WIDTH{1'b0}},
    parameter int                 CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             accept;
    logic             pop;

    assign accept   = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign out_data = main_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Flush always drains to EMPTY; otherwise the entry count moves by accept minus pop.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_next = FULL;
                FULL: begin
                    if (accept && !pop) begin
                        state_next = SKID;
                    end else if (!accept && pop) begin
                        state_next = EMPTY;
                    end
                end
                SKID: if (pop) state_next = FULL;
                default: state_next = EMPTY;
            endcase
        end
    end

    // in_ready only looks at registered state and flush, so stalls never ripple upstream.
    always_comb begin
        in_ready  = (state != SKID) & ~flush;
        out_valid = (state != EMPTY);
        occupancy = 2'd0;
        case (state)
            FULL:    occupancy = 2'd1;
            SKID:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) main_q <= in_data;
                end
                FULL: begin
                    if (accept && pop) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q <= in_data;
                    end else if (pop) begin
                        main_q <= NOP_VALUE;
                    end
                end
                SKID: begin
                    if (pop) main_q <= skid_q;
                end
                default: begin
                    main_q <= NOP_VALUE;
                    skid_q <= NOP_VALUE;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    // Counters saturate and deliberately ignore flush; a pop in a flush cycle still counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (pop && xfer_cnt != {CNT_W{1'b1}}) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end
`else
    // CNT_W only sizes the statistics counters, which this build leaves out.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, fully registered pipeline stage register that replaces the fixed per-stage control latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a WIDTH-bit payload bundle with a valid/ready handshake and a 2-entry skid buffer, so back-pressure stalls do not need a combinational ready path through the pipe.
- A synchronous flush inserts a bubble carrying NOP_VALUE.
- Instantiated once per stage boundary in the ARM pipeline.

Parameters:
- WIDTH, 32, payload width in bits (instruction word or packed control bundle).
- NOP_VALUE, {WIDTH{1'b0}}, payload driven on out_data when the stage is empty or flushed.
- CNT_W, 16, width of the statistics counters (only used with PIPE_STAGE_STATS_EN).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  upstream payload valid
- in_data  input  WIDTH  upstream payload
- in_ready  output  1  stage can accept this cycle
- out_valid  output  1  out_data holds a live entry
- out_data  output  WIDTH  head entry payload
- out_ready  input  1  downstream accepts head entry
- occupancy  output  2  number of held entries (0..2)
- stall_cnt  output  CNT_W  only with PIPE_STAGE_STATS_EN
- xfer_cnt  output  CNT_W  only with PIPE_STAGE_STATS_EN

Behaviour:
- Single clock domain. Reset is synchronous and active-high: clk, reset.
- Internal storage: main register (drives out_data) and skid register.
- State encoding: EMPTY (0 entries), FULL (main valid), SKID (main and skid valid).
- Derived signals:
  - accept = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = (state != SKID) & ~flush. This is the only combinational input-to-output path.
  - out_valid = (state != EMPTY). occupancy: EMPTY=0, FULL=1, SKID=2. Both are registered-state decodes.
- Transitions, evaluated on rising clk; reset has priority over flush, and flush has priority over everything else:
  - EMPTY: accept -> FULL, main<=in_data. Otherwise stay.
  - FULL: accept & pop -> FULL, main<=in_data. accept & ~pop -> SKID, skid<=in_data. ~accept & pop -> EMPTY, main<=NOP_VALUE. Otherwise hold.
  - SKID: pop -> FULL, main<=skid. Otherwise hold (in_ready=0, so no accept).
- Latency: a payload accepted in cycle N appears on out_data with out_valid=1 in cycle N+1 when the stage was EMPTY or popping.
- Ordering is strictly FIFO. No payload is duplicated or dropped except by flush.
- Payload stability: while out_valid=1 and out_ready=0, out_data is held unchanged.
- Flush:
  - Next state is EMPTY; main<=NOP_VALUE, skid<=NOP_VALUE.
  - in_ready=0 in the flush cycle, so an in_valid presented then is not consumed; upstream must re-present or drop it.
  - A pop in the flush cycle still counts as a completed transfer of the old head.
- Reset:
  - State EMPTY; main=skid=NOP_VALUE; out_valid=0; occupancy=0; out_data=NOP_VALUE.
  - in_ready=1 in the cycle after reset deasserts; during reset in_ready follows the state decode (1 unless flush).
  - Reset mid-transfer discards all entries with no partial state.
- Boundaries:
  - Full (SKID): in_ready=0 until a pop occurs. After that pop, in_ready=1 in the following cycle.
  - Empty: out_ready is ignored and pop=0.
  - in_valid is ignored whenever in_ready=0.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- When defined:
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - xfer_cnt increments on each pop.
  - Both saturate at 2^CNT_W-1, clear on reset, and are unaffected by flush.
- When undefined:
  - stall_cnt and xfer_cnt ports and counter logic are absent.
  - Core behaviour is otherwise identical.

Test Plan:
- Reset held 2 cycles with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=0, occupancy=0; first post-reset accept of 32'hE3A01005 seen on out_data next cycle with out_valid=1.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the following consecutive cycles, occupancy stays 1, in_ready stays 1.
- Back-pressure: out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_data=0xA held. Then out_ready=1 -> 0xA, then 0xB, then out_valid=0 and out_data=NOP_VALUE.
- Flush while SKID holding 0x11/0x22 with in_valid=1 data 0x33 -> in_ready=0 that cycle; next cycle occupancy=0, out_valid=0, out_data=0; 0x33 never appears.
- Simultaneous pop and push in FULL holding 0x5 with in 0x6 -> next cycle out_data=0x6, occupancy=1, no skid use.
- PIPE_STAGE_STATS_EN, CNT_W=2: hold out_valid=1, out_ready=0 for 6 cycles -> stall_cnt saturates at 3. Then 2 pops -> xfer_cnt=2. A flush leaves both counters unchanged.
